// File: rtl/mips_pkg.sv
// Shared fetch-stage constants, state encoding and instruction field helpers.
package mips_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned INS_W  = 20;

  localparam logic [INS_W-1:0]  NOP_WORD = 20'h00000;
  localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

  // Opcode field shared with StallControl_Block.
  localparam int unsigned OPC_MSB = 19;
  localparam int unsigned OPC_LSB = 15;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD
  } fetch_state_e;

  function automatic logic [OPC_MSB-OPC_LSB:0] opcode_of(input logic [INS_W-1:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: stall/jump controls in, program memory and issue path.
interface instruction_fetch_unit_if;
  import mips_pkg::*;

  logic              stall;
  logic              stall_pm;
  logic              jump_en;
  logic [ADDR_W-1:0] jump_addr;
  logic [INS_W-1:0]  pm_data;
  logic [ADDR_W-1:0] pm_addr;
  logic [INS_W-1:0]  ins_pm;
  logic [ADDR_W-1:0] ins_pc;
  logic              ins_valid;

  // Fetch unit side.
  modport master (
    input  stall, stall_pm, jump_en, jump_addr, pm_data,
    output pm_addr, ins_pm, ins_pc, ins_valid
  );

  // Environment side: stall control, decode and program memory.
  modport slave (
    output stall, stall_pm, jump_en, jump_addr, pm_data,
    input  pm_addr, ins_pm, ins_pc, ins_valid
  );

endinterface

// File: rtl/pc_register.sv
// Program counter with next-PC priority mux and wrap-around increment.
module pc_register
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              hold_i,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next-PC priority: reset, jump, hold, increment (wraps naturally).
  always_comb begin
    pc_d = pc_q + ADDR_W'(1);
    if (reset) begin
      pc_d = RESET_PC;
    end else if (jump_en_i) begin
      pc_d = jump_addr_i;
    end else if (hold_i) begin
      pc_d = pc_q;
    end
  end

  // PC register, loaded every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign next_pc_o = pc_d;
  assign pc_o      = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives program memory, issues or re-issues words.
module instruction_fetch_unit
  import mips_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  instruction_fetch_unit_if.master  bus
);

  fetch_state_e      state_q, state_d;
  logic [INS_W-1:0]  hold_q, hold_d;
  logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] next_pc;
  logic              pc_hold;
  logic [INS_W-1:0]  issue_word;
  logic [ADDR_W-1:0] issue_pc;
  logic              issue_valid;

  // BOOT re-requests RESET_PC so its word is the first one issued in RUN.
  assign pc_hold = bus.stall || (state_q == BOOT);

  pc_register u_pc_register (
    .clk         (clk),
    .reset       (reset),
    .jump_en_i   (bus.jump_en),
    .jump_addr_i (bus.jump_addr),
    .hold_i      (pc_hold),
    .next_pc_o   (next_pc),
    .pc_o        (pc_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a jump outside BOOT always returns to RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (bus.stall_pm) state_d = HOLD;
      HOLD:    if (!bus.stall_pm) state_d = RUN;
      default: state_d = RUN;
    endcase
    if (bus.jump_en && (state_q != BOOT)) begin
      state_d = RUN;
    end
  end

  // Issue mux: NOP during reset/BOOT, held word under stall_pm, else memory data.
  always_comb begin
    issue_word  = NOP_WORD;
    issue_pc    = pc_q;
    issue_valid = 1'b0;
    if (reset) begin
      issue_pc = RESET_PC;
    end else if (state_q == BOOT) begin
      issue_pc = pc_q;
    end else if (bus.stall_pm) begin
      issue_word  = hold_q;
      issue_pc    = hold_pc_q;
      issue_valid = 1'b1;
    end else begin
      issue_word  = bus.pm_data;
      issue_pc    = pc_q;
      issue_valid = 1'b1;
    end
    hold_d    = issue_word;
    hold_pc_d = issue_pc;
  end

  // Hold registers track the issued word, so they keep their value under stall_pm.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q    <= NOP_WORD;
      hold_pc_q <= RESET_PC;
    end else begin
      hold_q    <= hold_d;
      hold_pc_q <= hold_pc_d;
    end
  end

  assign bus.pm_addr   = next_pc;
  assign bus.ins_pm    = issue_word;
  assign bus.ins_pc    = issue_pc;
  assign bus.ins_valid = issue_valid;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a synchronous program memory model.
module tb_instruction_fetch_unit;
  import mips_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory contents: word i = 0x10000+i, except address 3.
  function automatic logic [19:0] mem_word(input logic [7:0] a);
    if (a == 8'h03) return 20'ha0000;
    return 20'h10000 + {12'h000, a};
  endfunction

  // Synchronous read: data for pm_addr appears after the next edge.
  always @(posedge clk) bus.pm_data <= mem_word(bus.pm_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_issue(input string tag, input logic valid, input logic [19:0] word,
                           input logic [7:0] pc);
    chk({tag, "_valid"}, 32'(bus.ins_valid), 32'(valid));
    chk({tag, "_ins"},   32'(bus.ins_pm),    32'(word));
    chk({tag, "_pc"},    32'(bus.ins_pc),    32'(pc));
  endtask

  task automatic chk_state(input string tag, input fetch_state_e exp);
    chk({tag, "_state"}, 32'(dut.state_q), 32'(exp));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b1;
    bus.stall    = 1'b0;
    bus.stall_pm = 1'b0;
    bus.jump_en  = 1'b0;
    bus.jump_addr = 8'h00;

    // Reset held for two edges.
    tick; #1;
    chk("rst_addr", 32'(bus.pm_addr), 32'h00);
    chk_issue("rst", 1'b0, 20'h00000, 8'h00);
    tick;
    reset = 1'b0; #1;
    chk_state("boot", BOOT);
    chk_issue("boot", 1'b0, 20'h00000, 8'h00);
    chk("boot_addr", 32'(bus.pm_addr), 32'h00);

    tick; #1;
    chk_state("run0", RUN);
    chk_issue("run0", 1'b1, 20'h10000, 8'h00);
    chk("run0_addr", 32'(bus.pm_addr), 32'h01);
    tick; #1; chk_issue("run1", 1'b1, 20'h10001, 8'h01);
    tick; #1; chk_issue("run2", 1'b1, 20'h10002, 8'h02);
    tick; #1; chk_issue("run3", 1'b1, 20'ha0000, 8'h03);

    // stall_pm for two cycles; stall joins on the second and holds PC at 05.
    tick; bus.stall_pm = 1'b1; #1;
    chk_issue("spm1", 1'b1, 20'ha0000, 8'h03);
    chk("spm1_addr", 32'(bus.pm_addr), 32'h05);
    chk_state("spm1", RUN);
    tick; bus.stall = 1'b1; #1;
    chk_issue("spm2", 1'b1, 20'ha0000, 8'h03);
    chk("stall1_addr", 32'(bus.pm_addr), 32'h05);
    chk_state("spm2", HOLD);
    tick; bus.stall_pm = 1'b0; #1;
    chk_state("spm_rel", HOLD);
    chk_issue("stall2", 1'b1, 20'h10005, 8'h05);
    chk("stall2_addr", 32'(bus.pm_addr), 32'h05);
    tick; #1;
    chk_state("back_run", RUN);
    chk("stall3_addr", 32'(bus.pm_addr), 32'h05);
    chk_issue("stall3", 1'b1, 20'h10005, 8'h05);
    tick; bus.stall = 1'b0; #1;
    chk_issue("srel0", 1'b1, 20'h10005, 8'h05);
    chk("srel0_addr", 32'(bus.pm_addr), 32'h06);
    tick; #1; chk_issue("srel1", 1'b1, 20'h10006, 8'h06);

    // Jump to 0x40 at pc 0x0A.
    tick; tick; tick; tick;
    bus.jump_en = 1'b1; bus.jump_addr = 8'h40; #1;
    chk_issue("jmp0", 1'b1, 20'h1000a, 8'h0a);
    chk("jmp0_addr", 32'(bus.pm_addr), 32'h40);
    tick; bus.jump_en = 1'b0; #1;
    chk_issue("jmp1", 1'b1, 20'h10040, 8'h40);
    chk("jmp1_addr", 32'(bus.pm_addr), 32'h41);

    // Wrap-around from 0xFF.
    tick; bus.jump_en = 1'b1; bus.jump_addr = 8'hff; #1;
    chk("wrap_jaddr", 32'(bus.pm_addr), 32'hff);
    tick; bus.jump_en = 1'b0; #1;
    chk_issue("wrapff", 1'b1, 20'h100ff, 8'hff);
    chk("wrapff_addr", 32'(bus.pm_addr), 32'h00);
    tick; #1;
    chk_issue("wrap00", 1'b1, 20'h10000, 8'h00);

    // Jump wins over stall.
    tick; bus.jump_en = 1'b1; bus.stall = 1'b1; bus.jump_addr = 8'h20; #1;
    chk("js_addr", 32'(bus.pm_addr), 32'h20);
    tick; bus.jump_en = 1'b0; bus.stall = 1'b0; #1;
    chk_issue("js", 1'b1, 20'h10020, 8'h20);

    // Jump with stall_pm: held word issued, PC redirected, state stays RUN.
    tick; bus.jump_en = 1'b1; bus.stall_pm = 1'b1; bus.jump_addr = 8'h30; #1;
    chk_issue("jspm0", 1'b1, 20'h10020, 8'h20);
    chk("jspm0_addr", 32'(bus.pm_addr), 32'h30);
    tick; bus.jump_en = 1'b0; bus.stall_pm = 1'b0; #1;
    chk_issue("jspm1", 1'b1, 20'h10030, 8'h30);
    chk_state("jspm1", RUN);

    // Reset during stall and jump discards everything.
    tick; reset = 1'b1; bus.stall = 1'b1; bus.jump_en = 1'b1; bus.jump_addr = 8'h55; #1;
    chk("rst2_addr", 32'(bus.pm_addr), 32'h00);
    chk_issue("rst2", 1'b0, 20'h00000, 8'h00);
    tick; reset = 1'b0; bus.stall = 1'b0; bus.jump_en = 1'b0; #1;
    chk_state("boot2", BOOT);
    chk("boot2_valid", 32'(bus.ins_valid), 32'h0);
    chk("boot2_addr", 32'(bus.pm_addr), 32'h00);
    tick; #1;
    chk_state("run2b", RUN);
    chk_issue("run2b", 1'b1, 20'h10000, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage that sits directly upstream of StallControl_Block. It owns the program counter and drives the address to the 256x20 program memory.
- It delivers the 20-bit instruction word that StallControl_Block and decode consume.
- It honours `stall` (freeze the PC) and `stall_pm` (re-issue the held instruction word), both produced by StallControl_Block. It also accepts a jump redirect from decode.

Parameters:
- ADDR_W, 8, program counter and program memory address width.
- INS_W, 20, instruction word width.
- NOP_WORD, 20'h00000, word issued while no valid instruction is available.
- RESET_PC, 8'h00, first fetch address after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all state on a rising clk edge while high.
- stall  input  1  from StallControl_Block; hold the PC.
- stall_pm  input  1  from StallControl_Block; issue the held word instead of memory data.
- jump_en  input  1  from decode; redirect fetch this cycle.
- jump_addr  input  ADDR_W  jump target address.
- pm_data  input  INS_W  program memory read data. Memory is synchronous: the word for pm_addr arrives one cycle later.
- pm_addr  output  ADDR_W  program memory address (combinational next-PC).
- ins_pm  output  INS_W  issued instruction to StallControl_Block and decode.
- ins_pc  output  ADDR_W  address of the word currently on ins_pm.
- ins_valid  output  1  high when ins_pm is a real fetched word, not a NOP bubble.

Behaviour:
- Registers:
  - pc_q: address whose data is on pm_data this cycle.
  - hold_q: last issued word.
  - hold_pc_q: address of that word.
  - state_q.
- States:
  - BOOT: first cycle after reset; memory data not yet valid.
  - RUN: normal fetch.
  - HOLD: stall_pm was active last cycle.
- Reset (reset=1 at edge):
  - pc_q=RESET_PC, hold_q=NOP_WORD, hold_pc_q=RESET_PC, state_q=BOOT.
  - While reset is high: pm_addr=RESET_PC, ins_pm=NOP_WORD, ins_valid=0, ins_pc=RESET_PC.
  - Reset mid-stall or mid-jump discards all pending state.
- Next-PC, in priority order:
  1. reset -> RESET_PC.
  2. jump_en -> jump_addr.
  3. stall -> pc_q.
  4. otherwise pc_q+1, mod 2^ADDR_W (8'hFF wraps to 8'h00).
- pm_addr = next-PC; pc_q <= next-PC every cycle.
- Issued word, combinational:
  - BOOT -> NOP_WORD, ins_valid=0.
  - stall_pm=1 -> hold_q, ins_pc=hold_pc_q, ins_valid=1.
  - otherwise -> pm_data, ins_pc=pc_q, ins_valid=1.
- hold_q and hold_pc_q capture ins_pm and ins_pc every non-reset cycle. When stall_pm is high they therefore retain their value.
- Transitions:
  - BOOT -> RUN unconditionally.
  - RUN -> HOLD when stall_pm=1.
  - HOLD -> RUN when stall_pm=0.
  - jump_en in any non-BOOT state -> RUN. jump_en during BOOT is ignored except that the PC is still loaded.
- Simultaneous jump_en and stall: jump wins; the PC loads jump_addr.
- Simultaneous jump_en and stall_pm: this cycle still issues hold_q; the redirect takes effect in the PC.
- Jump latency: target word appears on ins_pm exactly one cycle after jump_en; no bubble is inserted.
- Stall latency: with stall held for N cycles, pm_addr repeats the same address for N cycles; the fetch stream resumes with no gap and no duplicate.

Decomposition:
- Shared package (mips_pkg): ADDR_W, INS_W, NOP_WORD, RESET_PC, the fetch state enum (BOOT/RUN/HOLD), and the opcode field position [19:15] shared with StallControl_Block.
- One natural sub-module: pc_register. It holds pc_q with the next-PC priority mux and wrap-around increment. Issue mux, hold registers and FSM stay at the top level.

Test Plan:
- Reset held 2 cycles, then released; memory holds word i = 20'h10000+i -> first cycle after release: ins_valid=0, ins_pm=20'h00000. Then ins_pm=10000, 10001, 10002 with ins_pc=00, 01, 02.
- stall=1 for 3 cycles starting at pc_q=05 -> pm_addr stays 05 for 3 cycles. After release, ins_pc sequence continues 05, 06 with no repeat or gap.
- stall_pm=1 for 2 cycles while ins_pm=20'ha0000 (ins_pc=03) -> ins_pm stays a0000 and ins_pc stays 03 for both cycles; state goes HOLD, then back to RUN.
- jump_en=1, jump_addr=8'h40 at pc_q=0A -> pm_addr=40 that cycle; next cycle ins_pm=10040, ins_pc=40.
- PC at 8'hFF with no stall -> pm_addr=00 next; ins_pc wraps FF -> 00.
- reset asserted during stall=1 and jump_en=1 -> pm_addr=00, ins_valid=0; state goes BOOT, then RUN with ins_pc=00.
